// File: rtl/block_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : block_xfer_seq
//  Purpose  : Block (multi-register) transfer sequencer. Moves the registers
//             selected by Reg_List between a register file and memory, one
//             word per memory handshake, in ascending register order at
//             ascending word addresses. Supports the four addressing modes
//             IA / IB / DA / DB and produces the written-back base value.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        : clock, all state updates on the rising edge
//    Rst        : asynchronous active-high reset
//    Start      : begin a transfer (sampled only in IDLE)
//    L          : 1 = load-multiple (mem -> regs), 0 = store-multiple
//    U, P       : U=1 increment / U=0 decrement; P=1 pre- / P=0 post-update
//    Reg_List   : register select mask, bit i selects register i
//    Base_Addr  : base address, sampled with Start
//    R_Addr     : register file read address (registered)
//    R_Data     : register file read data (combinational)
//    Write_Reg  : register file write strobe (captured on falling clk edge)
//    W_Addr     : register file write address
//    W_Data     : register file write data
//    Mem_Req    : memory request
//    Mem_Wr     : memory write (1) / read (0)
//    Mem_Addr   : memory word address
//    Mem_WData  : memory write data
//    Mem_Ack    : memory acknowledge (ignored while Mem_Req=0)
//    Mem_RData  : memory read data, valid with Mem_Ack
//    Busy       : high in REQ, WB and DONE
//    Done       : one-cycle completion pulse
//    New_Base   : written-back base value
// ============================================================================
module block_xfer_seq (
  input  logic        clk,
  input  logic        Rst,
  input  logic        Start,
  input  logic        L,
  input  logic        U,
  input  logic        P,
  input  logic [15:0] Reg_List,
  input  logic [31:0] Base_Addr,
  output logic [3:0]  R_Addr,
  input  logic [31:0] R_Data,
  output logic        Write_Reg,
  output logic [3:0]  W_Addr,
  output logic [31:0] W_Data,
  output logic        Mem_Req,
  output logic        Mem_Wr,
  output logic [31:0] Mem_Addr,
  output logic [31:0] Mem_WData,
  input  logic        Mem_Ack,
  input  logic [31:0] Mem_RData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] New_Base
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WB   = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic        load_q;
  logic [15:0] pending;
  logic [31:0] addr;
  logic [3:0]  raddr;
  logic [3:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] new_base;

  logic [4:0]  n_cnt;
  logic [31:0] four_n;
  logic [31:0] start_addr;
  logic [31:0] base_calc;
  logic [15:0] pend_rest;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction

  // Index of the lowest set bit; 0 for an all-zero mask.
  function automatic logic [3:0] lowest_idx(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  always_comb begin
    n_cnt     = popcount16(Reg_List);
    four_n    = {25'd0, n_cnt, 2'b00};
    base_calc = U ? (Base_Addr + four_n) : (Base_Addr - four_n);
    // The block always occupies 4n bytes walked upward; the mode only picks
    // where the lowest word sits relative to the base.
    case ({U, P})
      2'b10:   start_addr = Base_Addr;                   // IA
      2'b11:   start_addr = Base_Addr + 32'd4;           // IB
      2'b00:   start_addr = Base_Addr - four_n + 32'd4;  // DA
      default: start_addr = Base_Addr - four_n;          // DB
    endcase
    // Pending mask with the register currently being accessed removed.
    pend_rest = pending & (pending - 16'd1);
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) state_nxt = (Reg_List != 16'd0) ? REQ : DONE;
      end
      REQ: begin
        if (Mem_Ack) begin
          if (load_q)                 state_nxt = WB;
          else if (pend_rest != 16'd0) state_nxt = REQ;
          else                        state_nxt = DONE;
        end
      end
      WB: begin
        // pending was already trimmed when the ack was taken
        state_nxt = (pending != 16'd0) ? REQ : DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      load_q   <= 1'b0;
      pending  <= '0;
      addr     <= '0;
      raddr    <= '0;
      waddr    <= '0;
      wdata    <= '0;
      new_base <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            load_q   <= L;
            pending  <= Reg_List;
            addr     <= start_addr;
            raddr    <= lowest_idx(Reg_List);
            waddr    <= lowest_idx(Reg_List);
            new_base <= base_calc;
          end
        end
        REQ: begin
          if (Mem_Ack) begin
            pending <= pend_rest;
            if (load_q) begin
              // Hold the addresses so WB writes the register just read.
              wdata <= Mem_RData;
            end else if (pend_rest != 16'd0) begin
              addr  <= addr + 32'd4;
              raddr <= lowest_idx(pend_rest);
              waddr <= lowest_idx(pend_rest);
            end
          end
        end
        WB: begin
          if (pending != 16'd0) begin
            addr  <= addr + 32'd4;
            raddr <= lowest_idx(pending);
            waddr <= lowest_idx(pending);
          end
        end
        default: ;
      endcase
    end
  end

  assign R_Addr    = raddr;
  assign W_Addr    = waddr;
  assign W_Data    = wdata;
  assign Mem_Addr  = addr;
  assign New_Base  = new_base;
  assign Mem_Req   = (state == REQ);
  assign Mem_Wr    = (state == REQ) && !load_q;
  // Gated so the write data bus stays quiet outside store accesses and in reset.
  assign Mem_WData = ((state == REQ) && !load_q) ? R_Data : 32'd0;
  assign Write_Reg = (state == WB);
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_block_xfer_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_block_xfer_seq
//  Purpose  : Self-checking bench for block_xfer_seq. Expected memory
//             accesses and register write-backs are queued when a transfer
//             is launched and popped as the DUT performs them. Includes a
//             register file model, a memory model and an ack responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_block_xfer_seq;

  logic        clk = 1'b0;
  logic        Rst;
  logic        Start;
  logic        L;
  logic        U;
  logic        P;
  logic [15:0] Reg_List;
  logic [31:0] Base_Addr;
  logic [3:0]  R_Addr;
  logic [31:0] R_Data;
  logic        Write_Reg;
  logic [3:0]  W_Addr;
  logic [31:0] W_Data;
  logic        Mem_Req;
  logic        Mem_Wr;
  logic [31:0] Mem_Addr;
  logic [31:0] Mem_WData;
  logic        Mem_Ack = 1'b0;
  logic [31:0] Mem_RData;
  logic        Busy;
  logic        Done;
  logic [31:0] New_Base;

  block_xfer_seq dut (
    .clk       (clk),
    .Rst       (Rst),
    .Start     (Start),
    .L         (L),
    .U         (U),
    .P         (P),
    .Reg_List  (Reg_List),
    .Base_Addr (Base_Addr),
    .R_Addr    (R_Addr),
    .R_Data    (R_Data),
    .Write_Reg (Write_Reg),
    .W_Addr    (W_Addr),
    .W_Data    (W_Data),
    .Mem_Req   (Mem_Req),
    .Mem_Wr    (Mem_Wr),
    .Mem_Addr  (Mem_Addr),
    .Mem_WData (Mem_WData),
    .Mem_Ack   (Mem_Ack),
    .Mem_RData (Mem_RData),
    .Busy      (Busy),
    .Done      (Done),
    .New_Base  (New_Base)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
  } acc_t;

  typedef struct packed {
    logic [3:0]  idx;
    logic [31:0] data;
  } wb_t;

  acc_t        acc_q[$];
  wb_t         wb_q[$];

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          acc_seen = 0;
  int          done_cnt = 0;
  int          ack_delay = 0;
  bit          ack_noise = 1'b0;

  logic [31:0] regs [0:15];
  bit          regs_init = 1'b0;
  logic [31:0] mem_arr [0:1023];

  assign R_Data    = regs[R_Addr];
  assign Mem_RData = mem_arr[Mem_Addr[11:2]];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Ack responder, register file model and scoreboard consumer. Everything
  // here is evaluated at the falling edge, where DUT outputs are settled.
  int          ack_cnt = 0;
  bit          hold = 1'b0;
  logic [37:0] hold_vec = '0;
  bit          prev_wr = 1'b0;

  always @(negedge clk) begin
    logic ack_n;
    acc_t ea;
    wb_t  ew;
    if (!regs_init) begin
      for (int i = 0; i < 16; i++) regs[i] = 32'h1000_0000 + 32'(i) * 32'h111;
      regs[0] = 32'hA;
      regs[2] = 32'hB;
      regs_init = 1'b1;
    end
    if (Rst) begin
      Mem_Ack = 1'b0;
      ack_cnt = 0;
      hold    = 1'b0;
      prev_wr = 1'b0;
    end else begin
      if (Mem_Req) begin
        if (ack_cnt >= ack_delay) begin
          ack_n = 1'b1;
          ack_cnt = 0;
        end else begin
          ack_n = 1'b0;
          ack_cnt++;
        end
      end else begin
        ack_n = ack_noise && ($urandom_range(0, 1) == 1);
        ack_cnt = 0;
      end
      Mem_Ack = ack_n;

      if (hold) check_val("req_hold", 64'({Mem_Req, Mem_Wr, R_Addr, Mem_Addr}), 64'(hold_vec));
      hold     = Mem_Req && !ack_n;
      hold_vec = {Mem_Req, Mem_Wr, R_Addr, Mem_Addr};

      if (Mem_Req && ack_n) begin
        acc_seen++;
        if (acc_q.size() == 0) begin
          check_val("acc_unexpected", 64'(Mem_Addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ea = acc_q.pop_front();
          check_val("acc_addr", 64'(Mem_Addr), 64'(ea.addr));
          check_val("acc_wr", 64'(Mem_Wr), 64'(ea.wr));
          if (ea.wr) check_val("acc_wdata", 64'(Mem_WData), 64'(ea.wdata));
        end
      end

      if (Write_Reg) begin
        check_val("wr_single", 64'(prev_wr), 64'd0);
        check_val("wr_no_req", 64'(Mem_Req), 64'd0);
        if (wb_q.size() == 0) begin
          check_val("wb_unexpected", 64'(W_Addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          ew = wb_q.pop_front();
          check_val("wb_idx", 64'(W_Addr), 64'(ew.idx));
          check_val("wb_data", 64'(W_Data), 64'(ew.data));
        end
        regs[W_Addr] = W_Data;
      end
      prev_wr = Write_Reg;

      if (Done) done_cnt++;
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_ctl"}, 64'({Write_Reg, Mem_Req, Mem_Wr, Busy, Done, R_Addr, W_Addr}), 64'd0);
    check_val({tag, "_maddr"}, 64'(Mem_Addr), 64'd0);
    check_val({tag, "_mwdata"}, 64'(Mem_WData), 64'd0);
    check_val({tag, "_wdata"}, 64'(W_Data), 64'd0);
    check_val({tag, "_nbase"}, 64'(New_Base), 64'd0);
  endtask

  // Queue the accesses/write-backs a transfer must produce; returns the
  // expected New_Base and Done latency (cycles after the Start edge).
  task automatic push_expect(input bit l, input bit u, input bit p, input logic [15:0] list,
                             input logic [31:0] base, input int dly,
                             output logic [31:0] exp_nb, output int exp_lat);
    int          n;
    logic [31:0] a;
    acc_t        ea;
    wb_t         ew;
    n = $countones(list);
    // lowest word of the block, then walk upward
    if (u) a = p ? base + 32'd4 : base;
    else   a = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
    exp_nb = u ? base + 32'(4 * n) : base - 32'(4 * n);
    for (int i = 0; i < 16; i++) begin
      if (list[i]) begin
        ea.addr  = a;
        ea.wr    = !l;
        ea.wdata = l ? 32'd0 : regs[i];
        acc_q.push_back(ea);
        if (l) begin
          ew.idx  = 4'(i);
          ew.data = mem_arr[a[11:2]];
          wb_q.push_back(ew);
        end
        a = a + 32'd4;
      end
    end
    exp_lat = n * (dly + (l ? 2 : 1)) + 1;
  endtask

  task automatic launch(input bit l, input bit u, input bit p, input logic [15:0] list,
                        input logic [31:0] base);
    @(negedge clk);
    L = l; U = u; P = p; Reg_List = list; Base_Addr = base;
    Start = 1'b1;
  endtask

  task automatic do_xfer(input bit l, input bit u, input bit p, input logic [15:0] list,
                         input logic [31:0] base, input int dly, input bit restart);
    logic [31:0] exp_nb;
    int          exp_lat;
    int          t0;
    int          d0;
    int          k;
    ack_delay = dly;
    push_expect(l, u, p, list, base, dly, exp_nb, exp_lat);
    launch(l, u, p, list, base);
    t0 = cyc;
    d0 = done_cnt;
    @(negedge clk);
    Start = 1'b0;
    k = 0;
    while (!Done && k < 400) begin
      if (restart && Busy) Start = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      k++;
    end
    Start = 1'b0;
    if (!Done) begin
      check_val("done_timeout", 64'd0, 64'd1);
    end else begin
      check_val("latency", 64'(cyc - t0), 64'(exp_lat));
      check_val("new_base", 64'(New_Base), 64'(exp_nb));
      check_val("busy_in_done", 64'(Busy), 64'd1);
    end
    @(negedge clk);
    check_val("done_pulses", 64'(done_cnt - d0), 64'd1);
    check_val("idle_busy_done", 64'({Busy, Done}), 64'd0);
    check_val("nbase_hold", 64'(New_Base), 64'(exp_nb));
    check_val("acc_left", 64'(acc_q.size()), 64'd0);
    check_val("wb_left", 64'(wb_q.size()), 64'd0);
    acc_q.delete();
    wb_q.delete();
  endtask

  initial begin
    logic [31:0] nb_dummy;
    int          lat_dummy;
    int          a0;
    int          k;
    logic [31:0] r0_save;
    logic [31:0] r1_save;

    Rst = 1'b1; Start = 1'b0; L = 1'b0; U = 1'b0; P = 1'b0;
    Reg_List = '0; Base_Addr = '0;
    for (int i = 0; i < 1024; i++) mem_arr[i] = 32'hC0DE_0000 | 32'(i * 7);
    mem_arr[32'h1F8 >> 2] = 32'h11;
    mem_arr[32'h1FC >> 2] = 32'h22;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    Rst = 1'b0;
    @(negedge clk);

    // Store-multiple IA, two registers, immediate acks
    do_xfer(1'b0, 1'b1, 1'b0, 16'h0005, 32'h100, 0, 1'b0);
    check_val("ia_nbase_const", 64'(New_Base), 64'h108);
    // Store-multiple IB with a 3-cycle ack delay
    do_xfer(1'b0, 1'b1, 1'b1, 16'h0002, 32'h40, 3, 1'b0);
    // Load-multiple DB into R0 and R15
    do_xfer(1'b1, 1'b0, 1'b1, 16'h8001, 32'h200, 0, 1'b0);
    check_val("db_r0", 64'(regs[0]), 64'h11);
    check_val("db_r15", 64'(regs[15]), 64'h22);
    check_val("db_nbase_const", 64'(New_Base), 64'h1F8);
    // Empty list
    do_xfer(1'b0, 1'b1, 1'b0, 16'h0000, 32'h80, 0, 1'b0);
    check_val("empty_nbase_const", 64'(New_Base), 64'h80);

    // Reset right after the first ack of a load-multiple
    ack_delay = 0;
    r0_save = regs[0];
    r1_save = regs[1];
    push_expect(1'b1, 1'b1, 1'b0, 16'h0003, 32'h300, 0, nb_dummy, lat_dummy);
    a0 = acc_seen;
    launch(1'b1, 1'b1, 1'b0, 16'h0003, 32'h300);
    @(negedge clk);
    Start = 1'b0;
    k = 0;
    do begin
      @(posedge clk);
      k++;
    end while (acc_seen == a0 && k < 50);
    check_val("rst_first_ack", 64'(acc_seen - a0), 64'd1);
    #1 Rst = 1'b1;
    #1 check_all_zero("midrst");
    @(negedge clk);
    @(negedge clk);
    acc_q.delete();
    wb_q.delete();
    Rst = 1'b0;
    repeat (4) @(negedge clk);
    check_val("rst_r0_kept", 64'(regs[0]), 64'(r0_save));
    check_val("rst_r1_kept", 64'(regs[1]), 64'(r1_save));
    check_val("rst_idle", 64'(Busy), 64'd0);
    do_xfer(1'b1, 1'b1, 1'b0, 16'h0003, 32'h300, 0, 1'b0);

    // Start toggled while busy must be ignored
    a0 = acc_seen;
    do_xfer(1'b0, 1'b1, 1'b0, 16'h00F0, 32'h500, 0, 1'b1);
    check_val("restart_accesses", 64'(acc_seen - a0), 64'd4);

    // Address wrap below zero with DB
    do_xfer(1'b0, 1'b0, 1'b1, 16'h000F, 32'h8, 1, 1'b0);

    // Random mix with stray acks while idle
    ack_noise = 1'b1;
    for (int t = 0; t < 20; t++) begin
      do_xfer(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              16'($urandom), 32'($urandom_range(32'h100, 32'h2F0)) << 2,
              $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end
    ack_noise = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
